// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with ALU-control decode, plus the
//                EX-stage forwarding and ALUSrc operand selection.
//  Revision    : 1.0  initial release
// ============================================================================

module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic [4:0]      id_rd_i,
    input  logic [1:0]      id_alu_op_i,
    input  logic [2:0]      id_funct3_i,
    input  logic            id_funct7_5_i,
    input  logic            id_alu_src_i,
    input  logic            id_reg_write_i,
    input  logic            id_mem_read_i,
    input  logic            id_mem_write_i,
    input  logic            id_mem_to_reg_i,
    input  logic            id_branch_i,
    input  logic [1:0]      fwd_a_i,
    input  logic [1:0]      fwd_b_i,
    input  logic [XLEN-1:0] exmem_result_i,
    input  logic [XLEN-1:0] memwb_result_i,
    output logic [XLEN-1:0] ex_A_o,
    output logic [XLEN-1:0] ex_B_o,
    output logic [3:0]      ex_alu_control_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [4:0]      ex_rs1_o,
    output logic [4:0]      ex_rs2_o,
    output logic [4:0]      ex_rd_o,
    output logic            ex_valid_o,
    output logic            ex_reg_write_o,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic            ex_mem_to_reg_o,
    output logic            ex_branch_o,
    output logic            ex_illegal_o
);

    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_AND = 4'b0000;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch;
        logic            alu_src;
        logic            illegal;
        logic [3:0]      alu_ctrl;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } idex_t;

    // Bubble: everything zero except the ALU code, which idles at ADD.
    localparam idex_t c_BUBBLE = '{alu_ctrl: c_ALU_ADD, default: '0};

    idex_t           idex_q, idex_d;
    logic [3:0]      w_alu_ctrl;
    logic            w_alu_illegal;
    logic [XLEN-1:0] w_fwd_a, w_fwd_b;

    always_comb begin
        w_alu_ctrl    = c_ALU_ADD;
        w_alu_illegal = 1'b0;
        case (id_alu_op_i)
            2'b00: w_alu_ctrl = c_ALU_ADD;
            2'b01: w_alu_ctrl = c_ALU_SUB;
            default: begin
                case (id_funct3_i)
                    3'b000: w_alu_ctrl = (id_alu_op_i == 2'b10 && id_funct7_5_i)
                                         ? c_ALU_SUB : c_ALU_ADD;
                    3'b111: w_alu_ctrl = c_ALU_AND;
                    3'b110: w_alu_ctrl = c_ALU_OR;
                    default: w_alu_illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        idex_d = idex_q;
        if (flush_i) begin
            idex_d = c_BUBBLE;
        end else if (!stall_i) begin
            // Invalid slots still carry data, but can never commit side effects.
            idex_d.valid      = id_valid_i;
            idex_d.reg_write  = id_valid_i & id_reg_write_i;
            idex_d.mem_read   = id_valid_i & id_mem_read_i;
            idex_d.mem_write  = id_valid_i & id_mem_write_i;
            idex_d.mem_to_reg = id_valid_i & id_mem_to_reg_i;
            idex_d.branch     = id_valid_i & id_branch_i;
            idex_d.alu_src    = id_valid_i & id_alu_src_i;
            idex_d.illegal    = id_valid_i & w_alu_illegal;
            idex_d.alu_ctrl   = w_alu_ctrl;
            idex_d.rs1_data   = id_rs1_data_i;
            idex_d.rs2_data   = id_rs2_data_i;
            idex_d.imm        = id_imm_i;
            idex_d.rs1        = id_rs1_i;
            idex_d.rs2        = id_rs2_i;
            idex_d.rd         = id_rd_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idex_q <= c_BUBBLE;
        end else begin
            idex_q <= idex_d;
        end
    end

    always_comb begin
        case (fwd_a_i)
            2'b10:   w_fwd_a = exmem_result_i;
            2'b01:   w_fwd_a = memwb_result_i;
            default: w_fwd_a = idex_q.rs1_data;
        endcase
        case (fwd_b_i)
            2'b10:   w_fwd_b = exmem_result_i;
            2'b01:   w_fwd_b = memwb_result_i;
            default: w_fwd_b = idex_q.rs2_data;
        endcase
    end

    assign ex_A_o           = w_fwd_a;
    assign ex_B_o           = idex_q.alu_src ? idex_q.imm : w_fwd_b;
    assign ex_store_data_o  = w_fwd_b;
    assign ex_alu_control_o = idex_q.alu_ctrl;
    assign ex_rs1_o         = idex_q.rs1;
    assign ex_rs2_o         = idex_q.rs2;
    assign ex_rd_o          = idex_q.rd;
    assign ex_valid_o       = idex_q.valid;
    assign ex_reg_write_o   = idex_q.reg_write;
    assign ex_mem_read_o    = idex_q.mem_read;
    assign ex_mem_write_o   = idex_q.mem_write;
    assign ex_mem_to_reg_o  = idex_q.mem_to_reg;
    assign ex_branch_o      = idex_q.branch;
    assign ex_illegal_o     = idex_q.illegal & idex_q.valid;

endmodule

`default_nettype wire
